// File: rtl/bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : bp_cfg_loader
// Purpose  : Boot-time configuration master. After an optional start delay it
//            walks every core through five identity-register writes while the
//            core is held frozen. Once every core is programmed it issues one
//            unfreeze write per core. It then reports completion.
// Ports    : clk_i        - clock
//            reset_i      - asynchronous, active-high reset
//            cfg_v_o      - write request valid (decoded from state only)
//            cfg_ready_i  - config bus accepts the request this cycle
//            cfg_core_o   - target core index
//            cfg_addr_o   - config register address
//            cfg_data_o   - config write data
//            done_o       - every write accepted; sticky until reset
// Revision : 1.0 - initial release
// ============================================================================
module bp_cfg_loader #(
    parameter int num_core_p       = 2,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int start_delay_p    = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [cfg_core_width_p-1:0] cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    output logic                        done_o
);

    localparam int CORE_CNT_W = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int DLY_W      = (start_delay_p > 0) ? $clog2(start_delay_p + 1) : 1;

    localparam logic [CORE_CNT_W-1:0] LAST_CORE = CORE_CNT_W'(num_core_p - 1);
    localparam logic [DLY_W-1:0]      DLY_INIT  = DLY_W'(start_delay_p);
    localparam logic [2:0]            LAST_REG  = 3'd4;

    localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE = cfg_addr_width_p'(1);
    localparam logic [cfg_addr_width_p-1:0] ADDR_ICACHE = cfg_addr_width_p'(2);
    localparam logic [cfg_addr_width_p-1:0] ADDR_DCACHE = cfg_addr_width_p'(3);
    localparam logic [cfg_addr_width_p-1:0] ADDR_CCE    = cfg_addr_width_p'(4);
    localparam logic [cfg_addr_width_p-1:0] ADDR_HART   = cfg_addr_width_p'(5);

    localparam logic [1:0] E_WAIT    = 2'd0;
    localparam logic [1:0] E_PROG    = 2'd1;
    localparam logic [1:0] E_RELEASE = 2'd2;
    localparam logic [1:0] E_DONE    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CORE_CNT_W-1:0] core_q,  core_d;
    logic [2:0]            reg_q,   reg_d;
    logic [DLY_W-1:0]      delay_q, delay_d;

    logic                        w_valid;
    logic                        w_handshake;
    logic [cfg_data_width_p-1:0] w_core_ext;
    logic [cfg_data_width_p-1:0] w_core_x2;

    // Valid depends on state alone so the bus can never see a request that
    // reacts combinationally to its own ready.
    assign w_valid     = (state_q == E_PROG) || (state_q == E_RELEASE);
    assign w_handshake = w_valid && cfg_ready_i;
    assign w_core_ext  = cfg_data_width_p'(core_q);
    assign w_core_x2   = w_core_ext << 1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= E_WAIT;
            core_q  <= '0;
            reg_q   <= '0;
            delay_q <= DLY_INIT;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            reg_q   <= reg_d;
            delay_q <= delay_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: counters only move on an accepted write
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        core_d  = core_q;
        reg_d   = reg_q;
        delay_d = delay_q;
        case (state_q)
            E_WAIT: begin
                if (delay_q == '0) begin
                    state_d = E_PROG;
                    core_d  = '0;
                    reg_d   = '0;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            E_PROG: begin
                if (w_handshake) begin
                    if (reg_q == LAST_REG) begin
                        reg_d = '0;
                        if (core_q == LAST_CORE) begin
                            state_d = E_RELEASE;
                            core_d  = '0;
                        end else begin
                            core_d = core_q + 1'b1;
                        end
                    end else begin
                        reg_d = reg_q + 1'b1;
                    end
                end
            end
            E_RELEASE: begin
                if (w_handshake) begin
                    if (core_q == LAST_CORE) begin
                        state_d = E_DONE;
                    end else begin
                        core_d = core_q + 1'b1;
                    end
                end
            end
            E_DONE: begin
                state_d = E_DONE;
            end
            default: begin
                state_d = E_WAIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: payload comes from registered state and counters,
    // so it is naturally held stable across a stall.
    // ------------------------------------------------------------------
    always_comb begin
        cfg_v_o    = 1'b0;
        done_o     = 1'b0;
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        case (state_q)
            E_PROG: begin
                cfg_v_o    = 1'b1;
                cfg_core_o = cfg_core_width_p'(core_q);
                case (reg_q)
                    3'd0: begin
                        cfg_addr_o = ADDR_FREEZE;
                        cfg_data_o = cfg_data_width_p'(1);
                    end
                    3'd1: begin
                        cfg_addr_o = ADDR_ICACHE;
                        cfg_data_o = w_core_x2;
                    end
                    3'd2: begin
                        cfg_addr_o = ADDR_DCACHE;
                        cfg_data_o = w_core_x2 | cfg_data_width_p'(1);
                    end
                    3'd3: begin
                        cfg_addr_o = ADDR_CCE;
                        cfg_data_o = w_core_ext;
                    end
                    default: begin
                        cfg_addr_o = ADDR_HART;
                        cfg_data_o = w_core_ext;
                    end
                endcase
            end
            E_RELEASE: begin
                cfg_v_o    = 1'b1;
                cfg_core_o = cfg_core_width_p'(core_q);
                cfg_addr_o = ADDR_FREEZE;
                cfg_data_o = '0;
            end
            E_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                cfg_v_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_cfg_loader
// Purpose  : Directed self-checking bench for bp_cfg_loader. Three instances
//            cover 2 cores/delay 4, 1 core/delay 0 and 16 cores/delay 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_cfg_loader;

    logic clk;
    logic rst;

    logic        a_v, a_ready, a_done;
    logic [7:0]  a_core;
    logic [15:0] a_addr;
    logic [31:0] a_data;

    logic        b_v, b_ready, b_done;
    logic [7:0]  b_core;
    logic [15:0] b_addr;
    logic [31:0] b_data;

    logic        c_v, c_ready, c_done;
    logic [7:0]  c_core;
    logic [15:0] c_addr;
    logic [31:0] c_data;

    int vectors;
    int miscompares;

    bp_cfg_loader #(.num_core_p(2), .cfg_core_width_p(8), .cfg_addr_width_p(16),
                    .cfg_data_width_p(32), .start_delay_p(4)) u_dut_a (
        .clk_i(clk), .reset_i(rst), .cfg_v_o(a_v), .cfg_ready_i(a_ready),
        .cfg_core_o(a_core), .cfg_addr_o(a_addr), .cfg_data_o(a_data), .done_o(a_done));

    bp_cfg_loader #(.num_core_p(1), .cfg_core_width_p(8), .cfg_addr_width_p(16),
                    .cfg_data_width_p(32), .start_delay_p(0)) u_dut_b (
        .clk_i(clk), .reset_i(rst), .cfg_v_o(b_v), .cfg_ready_i(b_ready),
        .cfg_core_o(b_core), .cfg_addr_o(b_addr), .cfg_data_o(b_data), .done_o(b_done));

    bp_cfg_loader #(.num_core_p(16), .cfg_core_width_p(8), .cfg_addr_width_p(16),
                    .cfg_data_width_p(32), .start_delay_p(2)) u_dut_c (
        .clk_i(clk), .reset_i(rst), .cfg_v_o(c_v), .cfg_ready_i(c_ready),
        .cfg_core_o(c_core), .cfg_addr_o(c_addr), .cfg_data_o(c_data), .done_o(c_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written write list for the two-core configuration.
    int p1_core [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1};
    int p1_addr [12] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 1};
    int p1_data [12] = '{1, 0, 1, 0, 0, 1, 2, 3, 1, 1, 0, 0};

    // Reference write order for n cores: 5 programming writes per core,
    // then one unfreeze per core.
    function automatic logic [63:0] exp_core(input int n, input int idx);
        if (idx < 5 * n) return 64'(idx / 5);
        return 64'(idx - 5 * n);
    endfunction

    function automatic logic [63:0] exp_addr(input int n, input int idx);
        if (idx < 5 * n) return 64'(idx % 5 + 1);
        return 64'd1;
    endfunction

    function automatic logic [63:0] exp_data(input int n, input int idx);
        int c;
        if (idx >= 5 * n) return 64'd0;
        c = idx / 5;
        case (idx % 5)
            0:       return 64'd1;
            1:       return 64'(2 * c);
            2:       return 64'(2 * c + 1);
            default: return 64'(c);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset deasserted just after an edge; the next edge is the first
    // one with reset low.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int  idx;
        bit  hs;
        bit  started;
        bit  found;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        a_ready     = 1'b1;
        b_ready     = 1'b1;
        c_ready     = 1'b1;

        // ---------------- Reset state ----------------
        @(posedge clk);
        #1;
        check("rst_a_v",    64'(a_v),    64'd0);
        check("rst_a_core", 64'(a_core), 64'd0);
        check("rst_a_addr", 64'(a_addr), 64'd0);
        check("rst_a_data", 64'(a_data), 64'd0);
        check("rst_a_done", 64'(a_done), 64'd0);
        check("rst_b_v",    64'(b_v),    64'd0);

        // ---------------- 2 cores, delay 4, ready high ----------------
        do_reset();
        for (int cyc = 0; cyc <= 16; cyc++) begin
            tick();
            if (cyc < 4) begin
                check("p1_idle_v", 64'(a_v), 64'd0);
            end else if (cyc < 16) begin
                check("p1_v",    64'(a_v),    64'd1);
                check("p1_core", 64'(a_core), 64'(p1_core[cyc-4]));
                check("p1_addr", 64'(a_addr), 64'(p1_addr[cyc-4]));
                check("p1_data", 64'(a_data), 64'(p1_data[cyc-4]));
                check("p1_done_low", 64'(a_done), 64'd0);
            end else begin
                check("p1_done", 64'(a_done), 64'd1);
                check("p1_v_after_done", 64'(a_v), 64'd0);
            end
        end
        tick();
        check("p1_done_sticky", 64'(a_done), 64'd1);

        // ---------------- 2 cores, random ready at 30% ----------------
        a_ready = 1'b0;
        do_reset();
        idx     = 0;
        hs      = 1'b0;
        started = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            if (hs) idx++;
            if (idx == 12) break;
            check("p2_done_low", 64'(a_done), 64'd0);
            if (a_v) started = 1'b1;
            if (started) begin
                check("p2_v",    64'(a_v),    64'd1);
                check("p2_core", 64'(a_core), 64'(p1_core[idx]));
                check("p2_addr", 64'(a_addr), 64'(p1_addr[idx]));
                check("p2_data", 64'(a_data), 64'(p1_data[idx]));
            end
            a_ready = ($urandom_range(99, 0) < 30);
            hs      = a_v && a_ready;
        end
        check("p2_handshakes", 64'(idx), 64'd12);
        check("p2_done", 64'(a_done), 64'd1);
        check("p2_v_after_done", 64'(a_v), 64'd0);

        // ---------------- 1 core, delay 0 ----------------
        b_ready = 1'b1;
        do_reset();
        for (int cyc = 0; cyc <= 6; cyc++) begin
            tick();
            if (cyc < 6) begin
                check("p3_v",    64'(b_v),    64'd1);
                check("p3_core", 64'(b_core), exp_core(1, cyc));
                check("p3_addr", 64'(b_addr), exp_addr(1, cyc));
                check("p3_data", 64'(b_data), exp_data(1, cyc));
            end else begin
                check("p3_done", 64'(b_done), 64'd1);
            end
        end

        // ---------------- Reset mid-stall at core 1 reg 0x0003 ----------------
        a_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (a_v && a_core == 8'd1 && a_addr == 16'd3) begin
                found = 1'b1;
                break;
            end
        end
        check("p4_reached_target", 64'(found), 64'd1);
        a_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            tick();
            check("p4_stall_v",    64'(a_v),    64'd1);
            check("p4_stall_core", 64'(a_core), 64'd1);
            check("p4_stall_addr", 64'(a_addr), 64'd3);
            check("p4_stall_data", 64'(a_data), 64'd3);
        end
        #2;
        a_ready = 1'b1;
        rst     = 1'b1;
        #1;
        check("p4_async_v",    64'(a_v),    64'd0);
        check("p4_async_core", 64'(a_core), 64'd0);
        check("p4_async_addr", 64'(a_addr), 64'd0);
        check("p4_async_data", 64'(a_data), 64'd0);
        check("p4_async_done", 64'(a_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int cyc = 0; cyc <= 5; cyc++) begin
            tick();
            if (cyc < 4) begin
                check("p4_idle_v", 64'(a_v), 64'd0);
            end else begin
                check("p4_core", 64'(a_core), 64'(p1_core[cyc-4]));
                check("p4_addr", 64'(a_addr), 64'(p1_addr[cyc-4]));
                check("p4_data", 64'(a_data), 64'(p1_data[cyc-4]));
            end
        end

        // ---------------- 16 cores ----------------
        c_ready = 1'b1;
        do_reset();
        idx = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            if (c_done) break;
            if (c_v) begin
                if (idx < 96) begin
                    check("p5_core", 64'(c_core), exp_core(16, idx));
                    check("p5_addr", 64'(c_addr), exp_addr(16, idx));
                    check("p5_data", 64'(c_data), exp_data(16, idx));
                end
                if (idx == 76) check("p5_icache15", 64'(c_data), 64'd30);
                if (idx == 77) check("p5_dcache15", 64'(c_data), 64'd31);
                if (idx == 78) check("p5_cce15",    64'(c_data), 64'd15);
                if (idx == 95) check("p5_last_core", 64'(c_core), 64'd15);
                idx++;
            end
        end
        check("p5_writes", 64'(idx), 64'd96);
        check("p5_done",   64'(c_done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_cfg_loader.md
# bp_cfg_loader

Boot-time configuration master that sits directly downstream of the processor configuration selection and feeds the per-core config bus. It turns the selected configuration's core count and config-bus widths into a fixed, ordered sequence of register writes. First it holds every core in freeze and programs its identity registers. Then it releases all cores. It drives a valid/ready write port and reports completion.

## Interface
Parameters:
- num_core_p, 2, number of cores to program (1..2^cfg_core_width_p)
- cfg_core_width_p, 8, core select width
- cfg_addr_width_p, 16, config register address width
- cfg_data_width_p, 32, config write data width
- start_delay_p, 4, idle cycles after reset deassertion before the first write (0 allowed)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- cfg_v_o  out  1  write request valid
- cfg_ready_i  in  1  config bus accepts the request this cycle
- cfg_core_o  out  cfg_core_width_p  target core index
- cfg_addr_o  out  cfg_addr_width_p  register address
- cfg_data_o  out  cfg_data_width_p  write data
- done_o  out  1  all writes accepted; sticky until reset

## Operation
- States: e_wait, e_prog, e_release, e_done.
- e_wait: a down-counter loads start_delay_p on reset and decrements each cycle. At 0 the block enters e_prog with core=0 and reg=0.
- e_prog: for each core c from 0 to num_core_p-1, the block issues five writes in this order:
  - addr 0x0001 freeze, data 1
  - addr 0x0002 icache LCE id, data 2c
  - addr 0x0003 dcache LCE id, data 2c+1
  - addr 0x0004 CCE id, data c
  - addr 0x0005 hart id, data c
- After the last write of core num_core_p-1 is accepted, the block enters e_release with core=0.
- e_release: for each core c from 0 to num_core_p-1, one write: addr 0x0001, data 0. No core is unfrozen until every core has been fully programmed.
- After the final release handshake the block enters e_done and raises done_o. It issues no further requests.
- Handshake: a write completes on a cycle where cfg_v_o && cfg_ready_i. The reg index and core counters advance only on a handshake.
- While cfg_v_o=1 and cfg_ready_i=0, core, addr and data are held stable and cfg_v_o stays high. There is no retraction.
- cfg_v_o is combinational from state only (1 in e_prog and e_release). It never depends on cfg_ready_i.
- Data values are zero-extended to cfg_data_width_p. The core index is zero-extended or truncated to cfg_core_width_p.
- Total writes: 6*num_core_p.
- Reset asserted at any point, including mid-handshake or with cfg_ready_i high, aborts the sequence immediately. No partial handshake is counted. After deassertion the sequence restarts from e_wait.

## Timing
- Reset values: cfg_v_o=0, cfg_core_o=0, cfg_addr_o=0, cfg_data_o=0, done_o=0, state=e_wait.
- First cfg_v_o=1 appears start_delay_p cycles after the first rising edge with reset_i low. With start_delay_p=0 it appears on the first cycle after reset.
- With cfg_ready_i tied high: one write per cycle, back-to-back, no bubbles, including across core and phase boundaries.
- done_o rises on the cycle after the final handshake, i.e. start_delay_p + 6*num_core_p cycles after reset release when there are no stalls. done_o stays high until reset.
- Outputs are registered or state-decoded. There is no combinational path from cfg_ready_i to any output.

## Test plan
- num_core_p=2, start_delay_p=4, cfg_ready_i=1 -> 12 consecutive writes starting at cycle 4:
  - (0,1,1),(0,2,0),(0,3,1),(0,4,0),(0,5,0)
  - (1,1,1),(1,2,2),(1,3,3),(1,4,1),(1,5,1)
  - (0,1,0),(1,1,0)
  - done_o=1 at cycle 16.
- Random cfg_ready_i at 30% -> identical ordered write list; payload stable and cfg_v_o high throughout every stall; done_o only after the 12th handshake.
- num_core_p=1, start_delay_p=0 -> 6 writes beginning in the first post-reset cycle; last write is (0,1,0).
- Reset pulsed during core 1 reg 0x0003 while stalled -> all outputs return to 0 asynchronously; after release the full sequence restarts from (0,1,1).
- num_core_p=16, cfg_core_width_p=8 -> 96 writes; core 15 gets icache id 30, dcache id 31, CCE id 15; all 16 freeze=0 writes come last.
